// File: rtl/clk_duty_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module : clk_meter_pkg
//  Brief  : Shared types and helpers for the clock duty-cycle meter.
//  Rev    : 1.0  initial release
// ============================================================================
package clk_meter_pkg;

    // Measurement FSM: IDLE/WAIT_RISE discard the partial first phase,
    // HIGH/LOW count the two phases of a full period.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } meter_state_t;

    // Width of a counter that must be able to hold the value TIMEOUT itself.
    function automatic int edge_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_duty_meter_if.sv
`default_nettype none
// ============================================================================
//  Module : clk_duty_meter_if
//  Brief  : Signal bundle between the measured source and the duty meter.
//           master = side driving sig_in, slave = the meter.
//  Rev    : 1.0  initial release
// ============================================================================
interface clk_duty_meter_if #(
    parameter int CNT_W = 16
);
    logic               sig_in;
    logic [CNT_W-1:0]   ton;
    logic [CNT_W-1:0]   toff;
    logic [CNT_W:0]     period;
    logic               meas_valid;
    logic               ovf;
    logic               no_clk;

    modport master (
        output sig_in,
        input  ton, toff, period, meas_valid, ovf, no_clk
    );

    modport slave (
        input  sig_in,
        output ton, toff, period, meas_valid, ovf, no_clk
    );
endinterface
`default_nettype wire

// File: rtl/clk_duty_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module : sync_edge_det
//  Brief  : Multi-flop synchronizer for an asynchronous input followed by a
//           one-cycle delay for rise/fall detection.
//  Rev    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic sig_i,
    output logic      sig_s_o,
    output logic      rise_o,
    output logic      fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;

    // Shift the raw input through the synchronizer and keep one cycle of history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            sig_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sig_s_o & ~sig_d_q;
    assign fall_o  = ~sig_s_o &  sig_d_q;
endmodule
`default_nettype wire

// File: rtl/clk_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module : clk_duty_meter
//  Brief  : Measures high time, low time and period of a pulse train in
//           clk100 cycles; flags saturated phases and loss of toggling.
//  Rev    : 1.0  initial release
// ============================================================================
module clk_duty_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  wire logic      clk100,
    input  wire logic      rst,
    clk_duty_meter_if.slave bus
);
    localparam int               EW      = edge_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [EW-1:0]    TO_VAL  = EW'(TIMEOUT);

    logic w_sig_s, w_rise, w_fall, w_edge, w_timeout;

    meter_state_t       state_q, state_d;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
    logic               phase_sat_q, phase_sat_d;
    logic [EW-1:0]      edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]   ton_q, ton_d;
    logic [CNT_W-1:0]   toff_q, toff_d;
    logic [CNT_W:0]     period_q, period_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               no_clk_q, no_clk_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk100),
        .rst_i   (rst),
        .sig_i   (bus.sig_in),
        .sig_s_o (w_sig_s),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    // Next-state logic: FSM, phase counters, inactivity timer and publish path.
    always_comb begin
        state_d     = state_q;
        hi_cnt_d    = hi_cnt_q;
        lo_cnt_d    = lo_cnt_q;
        phase_sat_d = phase_sat_q;
        ton_d       = ton_q;
        toff_d      = toff_q;
        period_d    = period_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;
        no_clk_d    = no_clk_q;

        // Inactivity timer; an edge always wins over an expiring timer.
        if (w_edge)
            edge_cnt_d = '0;
        else if (edge_cnt_q != TO_VAL)
            edge_cnt_d = edge_cnt_q + EW'(1);
        else
            edge_cnt_d = edge_cnt_q;
        w_timeout = !w_edge && (edge_cnt_d == TO_VAL);

        if (w_fall)
            no_clk_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_fall)
                    state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    state_d     = HIGH;
                    hi_cnt_d    = CNT_W'(1);
                    phase_sat_d = 1'b0;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    state_d  = LOW;
                    lo_cnt_d = CNT_W'(1);
                end else if (w_sig_s) begin
                    if (hi_cnt_q == CNT_MAX) phase_sat_d = 1'b1;
                    else                     hi_cnt_d    = hi_cnt_q + CNT_W'(1);
                end
            end
            LOW: begin
                if (w_rise) begin
                    ton_d       = hi_cnt_q;
                    toff_d      = lo_cnt_q;
                    period_d    = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
                    ovf_d       = phase_sat_q;
                    valid_d     = 1'b1;
                    state_d     = HIGH;
                    hi_cnt_d    = CNT_W'(1);
                    phase_sat_d = 1'b0;
                end else if (!w_sig_s) begin
                    if (lo_cnt_q == CNT_MAX) phase_sat_d = 1'b1;
                    else                     lo_cnt_d    = lo_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Loss of toggling abandons the measurement; published values hold.
        if (w_timeout) begin
            state_d     = IDLE;
            no_clk_d    = 1'b1;
            phase_sat_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q     <= IDLE;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            phase_sat_q <= 1'b0;
            edge_cnt_q  <= '0;
            ton_q       <= '0;
            toff_q      <= '0;
            period_q    <= '0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            no_clk_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            phase_sat_q <= phase_sat_d;
            edge_cnt_q  <= edge_cnt_d;
            ton_q       <= ton_d;
            toff_q      <= toff_d;
            period_q    <= period_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            no_clk_q    <= no_clk_d;
        end
    end

    assign bus.ton        = ton_q;
    assign bus.toff       = toff_q;
    assign bus.period     = period_q;
    assign bus.ovf        = ovf_q;
    assign bus.meas_valid = valid_q;
    assign bus.no_clk     = no_clk_q;
endmodule
`default_nettype wire

// File: tb/tb_clk_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module : tb_clk_duty_meter
//  Brief  : Self-checking bench for clk_duty_meter: directed scenarios plus
//           random pulse trains compared against an edge-timestamp model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_clk_duty_meter;
    localparam int CNT_W  = 4;
    localparam int SYNC   = 2;
    localparam int TO     = 50;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam int SAMP_N = 40000;

    logic clk100 = 1'b0;
    logic rst    = 1'b1;
    always #5 clk100 = ~clk100;

    clk_duty_meter_if #(.CNT_W(CNT_W)) bus ();

    clk_duty_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TO)
    ) dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Sampled input history and model state (times are clk100 edge indices).
    bit samp [0:SAMP_N-1];
    int k        = 0;
    int last_rst = 0;
    int m_last_edge, m_rise_t, m_fall_t;
    bit m_en, m_noclk, m_valid, m_ovf;
    int m_ton, m_toff, m_period;
    bit cur_lvl = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, k, obs, exp);
        end
    endtask

    // Input level as seen by the meter: anything sampled up to a reset is lost.
    function automatic bit view(input int j);
        if (j <= last_rst || j < 0) return 1'b0;
        return samp[j];
    endfunction

    task automatic model_reset();
        last_rst    = k;
        m_last_edge = k;
        m_rise_t    = -1;
        m_fall_t    = -1;
        m_en        = 1'b0;
        m_noclk     = 1'b0;
        m_valid     = 1'b0;
        m_ovf       = 1'b0;
        m_ton       = 0;
        m_toff      = 0;
        m_period    = 0;
    endtask

    // A rise/fall of the input is acted on SYNC edges after it is first sampled.
    // A period is published on a rise once a full high phase (rise..fall) has
    // been seen after a falling edge since the last reset/timeout.
    task automatic model_edge();
        bit a, b, rs, fl;
        int hi, lo;
        a  = view(k - SYNC);
        b  = view(k - SYNC - 1);
        rs = a & !b;
        fl = !a & b;
        m_valid = 1'b0;
        if (rs || fl) begin
            m_last_edge = k;
        end else if (k - m_last_edge >= TO) begin
            m_noclk  = 1'b1;
            m_en     = 1'b0;
            m_rise_t = -1;
        end
        if (fl) begin
            m_noclk  = 1'b0;
            m_en     = 1'b1;
            m_fall_t = k;
        end
        if (rs && m_en) begin
            if (m_rise_t >= 0 && m_fall_t > m_rise_t) begin
                hi       = m_fall_t - m_rise_t;
                lo       = k - m_fall_t;
                m_ton    = (hi > MAXC) ? MAXC : hi;
                m_toff   = (lo > MAXC) ? MAXC : lo;
                m_period = m_ton + m_toff;
                m_ovf    = (hi > MAXC) || (lo > MAXC);
                m_valid  = 1'b1;
            end
            m_rise_t = k;
        end
    endtask

    // One clk100 cycle: apply inputs, advance the model on the edge, then compare.
    task automatic step(input bit lvl, input bit r);
        bus.sig_in = lvl;
        rst        = r;
        cur_lvl    = lvl;
        @(posedge clk100);
        k++;
        samp[k] = lvl;
        if (r) model_reset();
        else   model_edge();
        #1;
        check("meas_valid", bus.meas_valid, m_valid);
        check("no_clk",     bus.no_clk,     m_noclk);
        check("ton",        bus.ton,        m_ton);
        check("toff",       bus.toff,       m_toff);
        check("period",     bus.period,     m_period);
        check("ovf",        bus.ovf,        m_ovf);
    endtask

    task automatic drive(input bit lvl, input int n);
        repeat (n) step(lvl, 1'b0);
    endtask

    task automatic toggle(input int hi, input int lo, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        bus.sig_in = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        check("rst_ton", bus.ton, 0);
        check("rst_period", bus.period, 0);
        check("rst_valid", bus.meas_valid, 0);

        // Steady 4 high / 6 low.
        toggle(4, 6, 5);
        check("steady_ton", bus.ton, 4);
        check("steady_toff", bus.toff, 6);
        check("steady_period", bus.period, 10);

        // Duty change to 2 / 8.
        toggle(2, 8, 3);
        check("duty_ton", bus.ton, 2);
        check("duty_toff", bus.toff, 8);
        check("duty_period", bus.period, 10);

        // Saturated high phase, then a normal period.
        drive(1'b1, 20); drive(1'b0, 3); drive(1'b1, 4);
        check("ovf_flag", bus.ovf, 1);
        check("ovf_ton", bus.ton, 15);
        check("ovf_toff", bus.toff, 3);
        check("ovf_period", bus.period, 18);
        drive(1'b0, 6); drive(1'b1, 4);
        check("ovf_clear", bus.ovf, 0);
        check("ovf_next_ton", bus.ton, 4);

        // Minimum pulse 1 / 1.
        repeat (10) begin
            drive(1'b0, 1);
            drive(1'b1, 1);
        end
        drive(1'b0, 3);
        check("min_ton", bus.ton, 1);
        check("min_toff", bus.toff, 1);
        check("min_period", bus.period, 2);

        // Stop toggling, then recover.
        drive(1'b0, 60);
        check("timeout_set", bus.no_clk, 1);
        check("timeout_hold_period", bus.period, 2);
        drive(1'b1, 5);
        check("timeout_rise_keeps", bus.no_clk, 1);
        drive(1'b0, 4);
        check("timeout_fall_clears", bus.no_clk, 0);
        toggle(4, 6, 3);
        check("recover_period", bus.period, 10);

        // Reset in the middle of a high phase with the input high at release.
        drive(1'b1, 2);
        step(1'b1, 1'b1);
        check("midrst_ton", bus.ton, 0);
        check("midrst_period", bus.period, 0);
        drive(1'b1, 5);
        drive(1'b0, 6); drive(1'b1, 4); drive(1'b0, 6); drive(1'b1, 4); drive(1'b0, 6);
        check("midrst_ton_after", bus.ton, 4);
        check("midrst_toff_after", bus.toff, 6);
        check("midrst_period_after", bus.period, 10);

        // Random pulse trains with occasional stalls and resets.
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0)
                drive(cur_lvl, int'($urandom_range(45, 70)));
            else if (sel == 1)
                repeat (int'($urandom_range(1, 2))) step(cur_lvl, 1'b1);
            drive(1'b1, int'($urandom_range(1, 20)));
            drive(1'b0, int'($urandom_range(1, 20)));
        end
        drive(1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/clk_duty_meter.md
# clk_duty_meter

Synthesizable measurement block for a generated clock or pulse train. It samples an asynchronous input `sig_in` on the `clk100` reference clock and reports high time, low time and period, all in `clk100` cycles. It also flags overflow and loss of toggling. It sits on the receive side of the clock-generation path and is used to check generator period and duty-cycle settings in silicon and in simulation.

## Interface
- `CNT_W`, 16: width of the `ton` and `toff` counters.
- `SYNC_STAGES`, 2: synchronizer depth; must be at least 2.
- `TIMEOUT`, 1000: number of `clk100` cycles without any edge before `no_clk` is asserted.

- `clk100`  in  1: reference clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sig_in`  in  1: asynchronous signal under measurement.
- `ton`  out  CNT_W: high-phase cycle count of the last completed period.
- `toff`  out  CNT_W: low-phase cycle count of the last completed period.
- `period`  out  CNT_W+1: equals `ton + toff`, no truncation.
- `meas_valid`  out  1: one-cycle pulse when `ton`/`toff`/`period` update.
- `ovf`  out  1: the published measurement had a saturated phase counter.
- `no_clk`  out  1: level; no edge was seen for `TIMEOUT` cycles.

## Operation
- Front end:
  - `sig_in` passes through `SYNC_STAGES` flops, giving `sig_s`.
  - `sig_d` is `sig_s` delayed by one cycle.
  - `rise = sig_s & !sig_d`; `fall = !sig_s & sig_d`.
- FSM states:
  - IDLE: waits for `fall`, then goes to WAIT_RISE.
  - WAIT_RISE: waits for `rise`, then goes to HIGH with `hi_cnt = 1`.
  - HIGH: increments `hi_cnt` each cycle. On `fall`, goes to LOW with `lo_cnt = 1`.
  - LOW: increments `lo_cnt` each cycle. On `rise`, publishes the measurement and returns to HIGH with `hi_cnt = 1`.
- The IDLE → WAIT_RISE sequence discards any partial first phase, including the false rise created when `sig_in` is already high as reset releases.
- Publish: `ton <= hi_cnt`, `toff <= lo_cnt`, `period <= hi_cnt + lo_cnt`, `ovf <= phase_sat`, `meas_valid <= 1`.
- Saturation: `hi_cnt` and `lo_cnt` hold at 2^CNT_W−1. `phase_sat` is set if either counter saturated in the current period and clears on publish.
- Timeout:
  - `edge_cnt` resets on `rise` or `fall` and otherwise increments, saturating at `TIMEOUT`.
  - When `edge_cnt` reaches `TIMEOUT`: `no_clk <= 1`, FSM goes to IDLE, and `ton`/`toff`/`period` hold their last values.
  - `no_clk` clears on the next `fall`.
- Simultaneous events: an edge and a timeout in the same cycle resolve to the edge; the timeout is not taken.

## Timing
- Reset values:
  - `ton`, `toff`, `period` = 0.
  - `meas_valid`, `ovf`, `no_clk` = 0.
  - FSM = IDLE.
  - Synchronizer flops, `sig_d` and all counters = 0.
- Latency: `meas_valid` is high in the cycle that starts `SYNC_STAGES` edges after the edge that first samples `sig_in` high, for the rising edge closing the period. The output registers update on that same edge.
- `meas_valid` is never high in two consecutive cycles. The minimum spacing between pulses is 2 cycles (1 high + 1 low).
- First `meas_valid` after reset or after a timeout: the second clean rising edge following a falling edge.
- Reset mid-operation: all state returns to reset values on the next edge. The in-flight measurement is dropped and no pulse is emitted.
- Resolution is ±1 `clk100` cycle per phase for asynchronous inputs. Inputs synchronous to `clk100` are measured exactly.

## Structure
- Package `clk_meter_pkg` contains:
  - `meter_state_t` enum: IDLE, WAIT_RISE, HIGH, LOW.
  - The timeout-counter width function (clog2 of `TIMEOUT` + 1).
- Sub-module `sync_edge_det`, parameter `SYNC_STAGES`: outputs `sig_s`, `rise` and `fall`.
- The top level holds the FSM, phase counters, timeout counter and output registers.

## Test plan
- Steady toggle: `sig_in` synchronous, 4 high / 6 low, 5 periods → `ton`=4, `toff`=6, `period`=10; `meas_valid` every 10 cycles; no pulse for the first partial period.
- Duty change: switch mid-stream to 2 high / 8 low → the next published values are `ton`=2, `toff`=8, `period`=10; no mixed sample is published.
- Overflow: `CNT_W`=4, 20 high / 3 low → `ton`=15, `toff`=3, `period`=18, `ovf`=1; the following normal period gives `ovf`=0.
- Timeout: `TIMEOUT`=50, stop toggling → `no_clk`=1 at cycle 50 after the last edge; a subsequent fall clears it; the next valid comes after two clean rises.
- Reset mid-HIGH plus high-at-release: assert `rst` for 1 cycle while `sig_in`=1, then hold high 5 cycles and resume 4/6 toggling → all outputs 0; no `meas_valid` until a full period following a fall; then 4/6/10.
- Minimum pulse: 1 high / 1 low → `ton`=1, `toff`=1, `period`=2; `meas_valid` every 2 cycles.
